imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined immediate generator for the decode stage. It accepts one 32-bit
//  instruction per cycle over a valid/ready handshake. For every RV32I/RV64I format it emits the
//  XLEN-wide immediate, a format code and an illegal-opcode flag. A 2-entry elastic buffer
//  decouples fetch from execute and sustains full throughput with a registered oReady.
// PARAMETERS
//  XLEN    32  output immediate width; legal values are 32 and 64 (64 also enables OP-IMM-32)
//  TAG_W   5   width of the sideband tag (PC index/ROB id) carried alongside each instruction
//  CSR_EN  1   1: SYSTEM CSR*I gives zimm; 0: SYSTEM gives 0 and is flagged illegal
// PORTS
//  iCLK          in   1       clock, rising edge
//  iRST_n        in   1       asynchronous reset, active-low
//  iValid        in   1       upstream instruction valid
//  oReady        out  1       buffer can accept (registered)
//  iInstruction  in   32      instruction word
//  iTag          in   TAG_W   sideband, passed through unmodified
//  oValid        out  1       head entry valid
//  iReady        in   1       downstream accepts head
//  oImmediate    out  XLEN    decoded immediate of head entry
//  oFmt          out  3       0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 shamt, 7 zimm
//  oIllegal      out  1       opcode not in table below
//  oTag          out  TAG_W   tag of head entry
// BEHAVIOUR
//  - Reset (iRST_n=0, async): state EMPTY; oValid=0, oReady=0; oImmediate, oFmt, oIllegal, oTag
//    all 0. oReady rises on the first clock edge after reset release.
//  - Push = iValid&oReady; pop = oValid&iReady. Decode is combinational on push, and the result
//    is stored in the entry, so outputs come straight from flops. Latency is 1 cycle from push
//    to oValid.
//  - FSM: EMPTY -push-> ONE. In ONE: push without pop -> TWO; pop without push -> EMPTY;
//    push and pop together -> ONE (the new entry becomes the head the next cycle). In TWO: pop
//    -> ONE (second entry promoted).
//  - oReady = (state!=TWO), registered. In TWO an offered instruction is not accepted and must
//    be held upstream. Entries are popped in push order; none is dropped or duplicated.
//  - Head outputs stay stable while oValid&!iReady.
//  - Decode by opcode iInstruction[6:0]. Sign bit is ins[31]; extend to XLEN:
//    0110111/0010111 LUI/AUIPC: U, {ins[31:12],12'b0} sign-extended
//    1101111 JAL: J, {ins[31],ins[19:12],ins[20],ins[30:21],1'b0}
//    1100111 JALR, 0000011 LOAD: I, ins[31:20]
//    0100011 STORE: S, {ins[31:25],ins[11:7]}
//    1100011 BRANCH: B, {ins[31],ins[7],ins[30:25],ins[11:8],1'b0}
//    0010011 OP-IMM: funct3 001/101 -> shamt, zero-extended ins[24:20] (ins[25:20] when XLEN=64);
//      otherwise I
//    0011011 OP-IMM-32 (XLEN=64 only; illegal when XLEN=32): shamt ins[24:20] for 001/101,
//      otherwise I
//    1110011 SYSTEM: funct3[2]=1 and CSR_EN -> zimm, zero-extended ins[19:15];
//      otherwise fmt none, imm 0
//    0001111 FENCE, 0110011/0111011 OP: fmt none, imm 0, legal
//    any other opcode: fmt none, imm 0, oIllegal=1
//  - Widths: all results are XLEN bits. Sign extension uses bit 31 of the instruction, never a
//    truncated field bit.
//  - Reset while entries are held discards them. No output is produced for a discarded entry.
// TESTING
//  - XLEN=32, push 0xFFF00093 (addi -1) -> next cycle oValid=1, imm 0xFFFFFFFF, fmt 1.
//  - Push 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, fmt 3. Push 0xFF9FF06F (jal -8) -> imm
//    0xFFFFFFF8, fmt 5.
//  - Push 0x123452B7 (lui) -> 0x12345000, fmt 4. Push 0x00000000 -> imm 0, fmt 0, oIllegal=1.
//  - XLEN=64, push 0xFE002E23 (sw -4) -> 0xFFFFFFFFFFFFFFFC, fmt 2. Push 0x03F09093 (slli 63)
//    -> 63, fmt 6. Push 0x300FD073 (csrrwi zimm 31) -> 0x1F, fmt 7.
//  - Hold iReady=0 and push 3 -> 2 accepted, oReady=0, head stable. Release iReady -> order
//    preserved. Random iValid/iReady over 10k instructions -> matches reference model, no loss.
//  - Assert iRST_n=0 mid-stream while in TWO -> outputs zero at once, no stale entry after
//    release.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe_if
// Brief    : Handshake bundle between fetch, the immediate generator and execute.
// Revision : 1.0
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic              iValid;
    logic              oReady;
    logic [31:0]       iInstruction;
    logic [TAG_W-1:0]  iTag;
    logic              oValid;
    logic              iReady;
    logic [XLEN-1:0]   oImmediate;
    logic [2:0]        oFmt;
    logic              oIllegal;
    logic [TAG_W-1:0]  oTag;

    modport slave (
        input  iValid, iInstruction, iTag, iReady,
        output oReady, oValid, oImmediate, oFmt, oIllegal, oTag
    );

    modport master (
        output iValid, iInstruction, iTag, iReady,
        input  oReady, oValid, oImmediate, oFmt, oIllegal, oTag
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : RV32I/RV64I immediate decoder behind a 2-entry elastic buffer.
// Revision : 1.0
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter bit CSR_EN = 1'b1
) (
    input  wire logic     iCLK,
    input  wire logic     iRST_n,
    imm_gen_pipe_if.slave bus
);
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_IMM32  = 7'b0011011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_OP32   = 7'b0111011;

    localparam logic [2:0] c_FMT_NONE  = 3'd0;
    localparam logic [2:0] c_FMT_I     = 3'd1;
    localparam logic [2:0] c_FMT_S     = 3'd2;
    localparam logic [2:0] c_FMT_B     = 3'd3;
    localparam logic [2:0] c_FMT_U     = 3'd4;
    localparam logic [2:0] c_FMT_J     = 3'd5;
    localparam logic [2:0] c_FMT_SHAMT = 3'd6;
    localparam logic [2:0] c_FMT_ZIMM  = 3'd7;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    logic [31:0]      w_ins;
    logic [6:0]       w_op;
    logic [2:0]       w_f3;
    logic [31:0]      w_imm32;
    logic             w_sext;
    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic             w_ill;
    logic             w_push;
    logic             w_pop;

    state_t           r_state;
    logic             r_ready;
    logic             r_valid;
    logic [XLEN-1:0]  r_h_imm;
    logic [2:0]       r_h_fmt;
    logic             r_h_ill;
    logic [TAG_W-1:0] r_h_tag;
    logic [XLEN-1:0]  r_t_imm;
    logic [2:0]       r_t_fmt;
    logic             r_t_ill;
    logic [TAG_W-1:0] r_t_tag;

    assign w_ins = bus.iInstruction;
    assign w_op  = w_ins[6:0];
    assign w_f3  = w_ins[14:12];

    // Fields are sign-extended to 32 bits here; w_sext widens that to XLEN.
    always_comb begin
        w_imm32 = 32'd0;
        w_sext  = 1'b0;
        w_fmt   = c_FMT_NONE;
        w_ill   = 1'b0;
        case (w_op)
            c_OP_LUI, c_OP_AUIPC: begin
                w_imm32 = {w_ins[31:12], 12'b0};
                w_sext  = 1'b1;
                w_fmt   = c_FMT_U;
            end
            c_OP_JAL: begin
                w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
                w_sext  = 1'b1;
                w_fmt   = c_FMT_J;
            end
            c_OP_JALR, c_OP_LOAD: begin
                w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
                w_sext  = 1'b1;
                w_fmt   = c_FMT_I;
            end
            c_OP_STORE: begin
                w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
                w_sext  = 1'b1;
                w_fmt   = c_FMT_S;
            end
            c_OP_BRANCH: begin
                w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
                w_sext  = 1'b1;
                w_fmt   = c_FMT_B;
            end
            c_OP_IMM: begin
                if (w_f3[1:0] == 2'b01) begin
                    w_imm32 = (XLEN == 64) ? {26'd0, w_ins[25:20]} : {27'd0, w_ins[24:20]};
                    w_fmt   = c_FMT_SHAMT;
                end else begin
                    w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
                    w_sext  = 1'b1;
                    w_fmt   = c_FMT_I;
                end
            end
            c_OP_IMM32: begin
                if (XLEN != 64) begin
                    w_ill = 1'b1;
                end else if (w_f3[1:0] == 2'b01) begin
                    w_imm32 = {27'd0, w_ins[24:20]};
                    w_fmt   = c_FMT_SHAMT;
                end else begin
                    w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
                    w_sext  = 1'b1;
                    w_fmt   = c_FMT_I;
                end
            end
            c_OP_SYSTEM: begin
                if (!CSR_EN) begin
                    w_ill = 1'b1;
                end else if (w_f3[2]) begin
                    w_imm32 = {27'd0, w_ins[19:15]};
                    w_fmt   = c_FMT_ZIMM;
                end
            end
            c_OP_FENCE, c_OP_OP, c_OP_OP32: begin
                w_fmt = c_FMT_NONE;
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    assign w_imm  = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);
    assign w_push = bus.iValid & r_ready;
    assign w_pop  = r_valid & bus.iReady;

    // Head holds the oldest entry and drives the outputs directly; tail only fills in S_TWO.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_h_imm <= '0;
            r_h_fmt <= '0;
            r_h_ill <= 1'b0;
            r_h_tag <= '0;
            r_t_imm <= '0;
            r_t_fmt <= '0;
            r_t_ill <= 1'b0;
            r_t_tag <= '0;
        end else begin
            r_ready <= 1'b1;
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_h_imm <= w_imm;
                        r_h_fmt <= w_fmt;
                        r_h_ill <= w_ill;
                        r_h_tag <= bus.iTag;
                        r_valid <= 1'b1;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_h_imm <= w_imm;
                        r_h_fmt <= w_fmt;
                        r_h_ill <= w_ill;
                        r_h_tag <= bus.iTag;
                    end else if (w_push) begin
                        r_t_imm <= w_imm;
                        r_t_fmt <= w_fmt;
                        r_t_ill <= w_ill;
                        r_t_tag <= bus.iTag;
                        r_ready <= 1'b0;
                        r_state <= S_TWO;
                    end else if (w_pop) begin
                        r_valid <= 1'b0;
                        r_state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        r_h_imm <= r_t_imm;
                        r_h_fmt <= r_t_fmt;
                        r_h_ill <= r_t_ill;
                        r_h_tag <= r_t_tag;
                        r_state <= S_ONE;
                    end else begin
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_EMPTY;
                end
            endcase
        end
    end

    assign bus.oReady     = r_ready;
    assign bus.oValid     = r_valid;
    assign bus.oImmediate = r_h_imm;
    assign bus.oFmt       = r_h_fmt;
    assign bus.oIllegal   = r_h_ill;
    assign bus.oTag       = r_h_tag;
endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Directed-vector bench driving XLEN=32 and XLEN=64 instances in lockstep.
// Revision : 1.0
// ============================================================================
module tb_imm_gen_pipe;
    localparam int c_NV = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        t_valid = 1'b0;
    logic        t_ready = 1'b0;
    logic [31:0] t_ins = 32'd0;
    logic [4:0]  t_tag = 5'd0;

    int n_vec = 0;
    int n_err = 0;
    int q[$];

    logic [31:0] v_ins   [c_NV];
    logic [31:0] v_imm32 [c_NV];
    logic [63:0] v_imm64 [c_NV];
    logic [2:0]  v_fmt32 [c_NV];
    logic [2:0]  v_fmt64 [c_NV];
    logic        v_ill32 [c_NV];
    logic        v_ill64 [c_NV];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) if64 ();

    assign if32.iValid = t_valid;  assign if64.iValid = t_valid;
    assign if32.iReady = t_ready;  assign if64.iReady = t_ready;
    assign if32.iInstruction = t_ins;  assign if64.iInstruction = t_ins;
    assign if32.iTag = t_tag;      assign if64.iTag = t_tag;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CSR_EN(1'b1)) u_dut32 (.iCLK(clk), .iRST_n(rst_n), .bus(if32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CSR_EN(1'b1)) u_dut64 (.iCLK(clk), .iRST_n(rst_n), .bus(if64));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] ins, input logic [31:0] i32,
                           input logic [63:0] i64, input logic [2:0] f32, input logic [2:0] f64,
                           input logic l32, input logic l64);
        v_ins[i] = ins; v_imm32[i] = i32; v_imm64[i] = i64;
        v_fmt32[i] = f32; v_fmt64[i] = f64; v_ill32[i] = l32; v_ill64[i] = l64;
    endtask

    task automatic check_head(input int e);
        chk("imm32", 64'(if32.oImmediate), 64'(v_imm32[e]));
        chk("fmt32", 64'(if32.oFmt), 64'(v_fmt32[e]));
        chk("ill32", 64'(if32.oIllegal), 64'(v_ill32[e]));
        chk("tag32", 64'(if32.oTag), 64'(e));
        chk("imm64", if64.oImmediate, v_imm64[e]);
        chk("fmt64", 64'(if64.oFmt), 64'(v_fmt64[e]));
        chk("ill64", 64'(if64.oIllegal), 64'(v_ill64[e]));
        chk("tag64", 64'(if64.oTag), 64'(e));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid32"}, 64'(if32.oValid), 64'd0);
        chk({tag, "_ready32"}, 64'(if32.oReady), 64'd0);
        chk({tag, "_imm32"}, 64'(if32.oImmediate), 64'd0);
        chk({tag, "_fmt32"}, 64'(if32.oFmt), 64'd0);
        chk({tag, "_ill32"}, 64'(if32.oIllegal), 64'd0);
        chk({tag, "_tag32"}, 64'(if32.oTag), 64'd0);
        chk({tag, "_valid64"}, 64'(if64.oValid), 64'd0);
        chk({tag, "_ready64"}, 64'(if64.oReady), 64'd0);
        chk({tag, "_imm64"}, if64.oImmediate, 64'd0);
        chk({tag, "_tag64"}, 64'(if64.oTag), 64'd0);
    endtask

    // One clock: drive at negedge, check the head popped by the coming edge, track pushes.
    task automatic cycle(input logic v, input int idx, input logic rdy, output logic acc);
        int e;
        @(negedge clk);
        t_valid = v; t_ins = v_ins[idx]; t_tag = 5'(idx); t_ready = rdy;
        #1;
        chk("valid32", 64'(if32.oValid), 64'(q.size() != 0));
        chk("valid64", 64'(if64.oValid), 64'(q.size() != 0));
        chk("ready32", 64'(if32.oReady), 64'(q.size() < 2));
        chk("ready64", 64'(if64.oReady), 64'(q.size() < 2));
        if (rdy && q.size() != 0) begin
            e = q.pop_front();
            check_head(e);
        end
        acc = v && (q.size() + (rdy && if32.oValid ? 1 : 0) < 2 || if32.oReady) && if32.oReady;
        acc = v && if32.oReady;
        if (acc) q.push_back(idx);
    endtask

    initial begin
        logic acc;
        int   budget;
        set_vec( 0, 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0);
        set_vec( 1, 32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 3'd3, 1'b0, 1'b0);
        set_vec( 2, 32'hFF9FF06F, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd5, 3'd5, 1'b0, 1'b0);
        set_vec( 3, 32'h123452B7, 32'h12345000, 64'h0000000012345000, 3'd4, 3'd4, 1'b0, 1'b0);
        set_vec( 4, 32'h00000000, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1);
        set_vec( 5, 32'hFE002E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0);
        set_vec( 6, 32'h03F09093, 32'h0000001F, 64'h000000000000003F, 3'd6, 3'd6, 1'b0, 1'b0);
        set_vec( 7, 32'h300FD073, 32'h0000001F, 64'h000000000000001F, 3'd7, 3'd7, 1'b0, 1'b0);
        set_vec( 8, 32'hFFF0009B, 32'h00000000, 64'hFFFFFFFFFFFFFFFF, 3'd0, 3'd1, 1'b1, 1'b0);
        set_vec( 9, 32'h00000033, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0);
        set_vec(10, 32'h00000073, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b0, 1'b0);
        set_vec(11, 32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4, 1'b0, 1'b0);
        set_vec(12, 32'h7FF02083, 32'h000007FF, 64'h00000000000007FF, 3'd1, 3'd1, 1'b0, 1'b0);
        set_vec(13, 32'h40505093, 32'h00000005, 64'h0000000000000005, 3'd6, 3'd6, 1'b0, 1'b0);
        set_vec(14, 32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1);
        set_vec(15, 32'hFFFFF017, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 3'd4, 3'd4, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;

        // Back-to-back stream with downstream always ready.
        for (int i = 0; i < c_NV; i++) cycle(1'b1, i, 1'b1, acc);
        repeat (2) cycle(1'b0, 0, 1'b1, acc);

        // Backpressure: third offer must be refused, head must hold.
        cycle(1'b1, 3, 1'b0, acc);
        cycle(1'b1, 4, 1'b0, acc);
        cycle(1'b1, 5, 1'b0, acc);
        chk("bp_third_refused", 64'(acc), 64'd0);
        @(posedge clk); #1;
        chk("bp_hold_tag", 64'(if32.oTag), 64'd3);
        chk("bp_hold_imm", if64.oImmediate, v_imm64[3]);
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 10) begin
            cycle(1'b1, 5, 1'b1, acc);
            budget++;
        end
        chk("bp_accept_timeout", 64'(acc), 64'd1);
        repeat (3) cycle(1'b0, 0, 1'b1, acc);

        // Random traffic against the in-order scoreboard.
        for (int n = 0; n < 12000; n++)
            cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, c_NV - 1)),
                  1'($urandom_range(0, 9) < 7), acc);
        repeat (4) cycle(1'b0, 0, 1'b1, acc);
        chk("drain_empty", 64'(q.size()), 64'd0);

        // Asynchronous reset while full discards both entries.
        cycle(1'b1, 1, 1'b0, acc);
        cycle(1'b1, 2, 1'b0, acc);
        cycle(1'b0, 0, 1'b0, acc);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1 check_zero("midrst");
        q.delete();
        @(negedge clk);
        t_ready = 1'b1;
        rst_n = 1'b1;
        repeat (3) cycle(1'b0, 0, 1'b1, acc);
        cycle(1'b1, 7, 1'b1, acc);
        cycle(1'b0, 0, 1'b1, acc);
        chk("post_reset_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
